// File: rtl/data_memory_stage.sv
// rtl/data_memory_stage.sv - byte-addressed data memory with self-clear after reset,
// sized loads/stores with sign extension, and misalignment/illegal-access fault detection.
module data_memory_stage #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] write_data_M,
  input  logic        ctrl_memory_WE_M,
  input  logic        ctrl_memory_RE_M,
  input  logic [2:0]  funct3_M,
  output logic [31:0] data_memory_RD_M,
  output logic        stall_M,
  output logic        misaligned_M,
  output logic        fault_sticky
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   clr_cnt;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            ready;

  logic [AW-1:0]   idx;
  logic [1:0]      boff;
  logic            unused_addr_bits;
  logic            align_err, illegal;
  logic            store_en;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  assign idx              = ALU_result_M[AW+1:2];
  assign boff             = ALU_result_M[1:0];
  assign unused_addr_bits = ^ALU_result_M[31:AW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_WORD) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    stall_M = (state == CLEAR);
    ready   = (state == READY);
  end

  always_comb begin
    align_err = 1'b0;
    illegal   = 1'b0;
    case (funct3_M)
      3'b000, 3'b100: align_err = 1'b0;
      3'b001, 3'b101: align_err = boff[0];
      3'b010:         align_err = |boff;
      default:        illegal   = 1'b1;
    endcase
  end

  assign misaligned_M = ready & (ctrl_memory_WE_M | ctrl_memory_RE_M) & (align_err | illegal);
  assign store_en     = ready & ctrl_memory_WE_M & ~misaligned_M;

  // Store data is replicated across lanes so the byte enables alone select what lands.
  always_comb begin
    case (funct3_M[1:0])
      2'b00: begin
        be    = 4'b0001 << boff;
        wdata = {4{write_data_M[7:0]}};
      end
      2'b01: begin
        be    = boff[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data_M[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = write_data_M;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (store_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Asynchronous read returns pre-write contents for a same-cycle store.
  assign rd_word = mem[idx];
  assign rd_half = boff[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (boff)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    data_memory_RD_M = '0;
    if (ready && ctrl_memory_RE_M && !misaligned_M) begin
      case (funct3_M)
        3'b000:  data_memory_RD_M = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  data_memory_RD_M = {24'b0, rd_byte};
        3'b001:  data_memory_RD_M = {{16{rd_half[15]}}, rd_half};
        3'b101:  data_memory_RD_M = {16'b0, rd_half};
        3'b010:  data_memory_RD_M = rd_word;
        default: data_memory_RD_M = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               fault_sticky <= 1'b0;
    else if (misaligned_M) fault_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// tb/tb_data_memory_stage.sv - directed vector table plus randomized accesses
// against a byte-array reference model of the data memory stage.
module tb_data_memory_stage;

  localparam int DEPTH = 256;
  localparam int MEMB  = 4 * DEPTH;

  logic        clk;
  logic        rst;
  logic [31:0] ALU_result_M;
  logic [31:0] write_data_M;
  logic        ctrl_memory_WE_M;
  logic        ctrl_memory_RE_M;
  logic [2:0]  funct3_M;
  logic [31:0] data_memory_RD_M;
  logic        stall_M;
  logic        misaligned_M;
  logic        fault_sticky;

  data_memory_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .ALU_result_M     (ALU_result_M),
    .write_data_M     (write_data_M),
    .ctrl_memory_WE_M (ctrl_memory_WE_M),
    .ctrl_memory_RE_M (ctrl_memory_RE_M),
    .funct3_M         (funct3_M),
    .data_memory_RD_M (data_memory_RD_M),
    .stall_M          (stall_M),
    .misaligned_M     (misaligned_M),
    .fault_sticky     (fault_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  mdl [MEMB];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic logic model_mis(input logic we, input logic re, input logic [31:0] a, input logic [2:0] f3);
    logic legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return (we || re) && (!legal || (a % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic re, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int sz, base;
    if (!re || model_mis(1'b0, re, a, f3)) return 32'h0;
    sz   = acc_size(f3);
    base = int'(a % MEMB);
    v    = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(mdl[(base + i) % MEMB]) << (8 * i));
    if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int base;
    if (we && !model_mis(we, re, a, f3)) begin
      base = int'(a % MEMB);
      for (int i = 0; i < acc_size(f3); i++) mdl[(base + i) % MEMB] = wd[8*i +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEMB; i++) mdl[i] = 8'h00;
  endtask

  // Drive one access, sample outputs mid-cycle, commit on the next rising edge.
  task automatic apply(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic mis);
    @(negedge clk);
    ctrl_memory_WE_M = we;
    ctrl_memory_RE_M = re;
    ALU_result_M     = a;
    write_data_M     = wd;
    funct3_M         = f3;
    #2;
    rd  = data_memory_RD_M;
    mis = misaligned_M;
    @(posedge clk);
    #1;
    ctrl_memory_WE_M = 1'b0;
    ctrl_memory_RE_M = 1'b0;
    model_store(we, re, a, wd, f3);
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (stall_M && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd, exp_rd, a, wd;
    logic        mis, exp_mis, we, re;
    logic [2:0]  f3;
    int          n;

    rst = 1'b1;
    ctrl_memory_WE_M = 1'b0;
    ctrl_memory_RE_M = 1'b1;
    ALU_result_M     = 32'h3;
    write_data_M     = 32'h0;
    funct3_M         = 3'b010;
    model_clear();

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check32("rst_stall", 32'(stall_M), 32'd1);
    check32("rst_fault", 32'(fault_sticky), 32'd0);
    check32("rst_rd", data_memory_RD_M, 32'h0);
    check32("rst_mis", 32'(misaligned_M), 32'd0);
    count_stall(n);
    ctrl_memory_RE_M = 1'b0;
    check32("clear_len", 32'(n), 32'd256);
    @(negedge clk);
    check32("fault_after_clear", 32'(fault_sticky), 32'd0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      apply(1'b0, 1'b1, a, 32'h0, 3'b010, rd, mis);
      check32("lw_after_clear", rd, 32'h0);
    end

    apply(1'b1, 1'b0, 32'h21, 32'h1122_3344, 3'b010, rd, mis);
    check32("sw_mis_flag", 32'(mis), 32'd1);
    check32("fault_next_cycle", 32'(fault_sticky), 32'd1);

    tbl.push_back('{1'b1, 1'b0, 32'h10,  32'h80FF_7F01, 3'd2, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h10,  32'h0,         3'd0, 32'h0000_0001, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h11,  32'h0,         3'd0, 32'h0000_007F, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h12,  32'h0,         3'd4, 32'h0000_00FF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h13,  32'h0,         3'd0, 32'hFFFF_FF80, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h12,  32'h0,         3'd1, 32'hFFFF_80FF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h10,  32'h0,         3'd5, 32'h0000_7F01, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h20,  32'hAAAA_AAAA, 3'd2, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h22,  32'hFFFF_FF55, 3'd0, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h20,  32'hABCD_1234, 3'd1, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h20,  32'h0,         3'd2, 32'hAA55_1234, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h21,  32'h1122_3344, 3'd2, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h23,  32'h0,         3'd1, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h20,  32'h0,         3'd2, 32'hAA55_1234, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h20,  32'h0,         3'd3, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h21,  32'h0,         3'd6, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h20,  32'h0,         3'd2, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h4,   32'hDEAD_BEEF, 3'd2, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h404, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h406, 32'h0,         3'd5, 32'h0000_DEAD, 1'b0});

    foreach (tbl[i]) begin
      apply(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, mis);
      check32($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      check32($sformatf("tbl%0d_mis", i), 32'(mis), 32'(tbl[i].exp_mis));
    end
    check32("fault_held", 32'(fault_sticky), 32'd1);

    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom);
      re = 1'($urandom);
      a  = $urandom & 32'hFFFF_FC3F;
      wd = $urandom;
      f3 = 3'($urandom_range(0, 7));
      exp_rd  = model_load(re, a, f3);
      exp_mis = model_mis(we, re, a, f3);
      apply(we, re, a, wd, f3, rd, mis);
      check32($sformatf("rnd%0d_rd a=%h f3=%0d", i, a, f3), rd, exp_rd);
      check32($sformatf("rnd%0d_mis", i), 32'(mis), 32'(exp_mis));
    end
    check32("fault_held_rnd", 32'(fault_sticky), 32'd1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    ctrl_memory_WE_M = 1'b1;
    ctrl_memory_RE_M = 1'b1;
    ALU_result_M     = 32'h10;
    write_data_M     = 32'hFFFF_FFFF;
    funct3_M         = 3'b010;
    #2;
    check32("clear_rd_zero", data_memory_RD_M, 32'h0);
    check32("clear_stall", 32'(stall_M), 32'd1);
    @(negedge clk);
    ctrl_memory_WE_M = 1'b0;
    ctrl_memory_RE_M = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("rst2_fault", 32'(fault_sticky), 32'd0);
    count_stall(n);
    check32("clear2_len", 32'(n), 32'd256);
    model_clear();

    for (int w = 0; w < DEPTH; w++) begin
      a = 32'(w * 4);
      exp_rd = model_load(1'b1, a, 3'b010);
      apply(1'b0, 1'b1, a, 32'h0, 3'b010, rd, mis);
      check32($sformatf("reclear_w%0d", w), rd, exp_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
